hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have port clock  input  1  the single rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports RA1D, RA2D  input  4 each  decode-stage source register addresses.
REQ-005 SHALL have port WA3D  input  4  decode-stage destination register, instruction[15:12].
REQ-006 SHALL have ports RegWriteE, RegWriteM, RegWriteW  input  1 each  per-stage register-write enables from the controller.
REQ-007 SHALL have port MemtoRegE  input  1  load instruction present in Execute.
REQ-008 SHALL have ports PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1 each  PC-write pending per stage.
REQ-009 SHALL have port BranchTakenE  input  1  taken branch resolved in Execute.
REQ-010 SHALL have ports ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-011 SHALL have ports StallF, StallD, FlushD, FlushE  output  1 each  pipeline stall and flush controls.
REQ-012 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  saturating counts of StallF cycles and FlushE cycles.

Function
REQ-013 SHALL hold shadow registers RA1E, RA2E, WA3E, loaded from RA1D, RA2D, WA3D on each rising edge when StallD=0.
REQ-014 SHALL clear RA1E, RA2E, WA3E to 0 on a rising edge where FlushE=1; flush SHALL take priority over load.
REQ-015 SHALL shift WA3M<=WA3E and WA3W<=WA3M on every rising edge, unaffected by stalls.
REQ-016 SHALL drive ForwardAE=10 when RA1E==WA3M and RegWriteM=1; otherwise 01 when RA1E==WA3W and RegWriteW=1; otherwise 00.
REQ-017 SHALL drive ForwardBE by the same rule using RA2E.
REQ-018 SHALL never forward when the matching address is 4'd15; R15 writes go through the PCSrc path.
REQ-019 SHALL compute LDRstall = MemtoRegE & RegWriteE & ((RA1D==WA3E)|(RA2D==WA3E)), combinationally, in the same cycle.
REQ-020 SHALL compute PCWrPending = PCSrcD|PCSrcE|PCSrcM.
REQ-021 SHALL drive StallF = LDRstall|PCWrPending.
REQ-022 SHALL drive StallD = LDRstall.
REQ-023 SHALL drive FlushD = PCWrPending|PCSrcW|BranchTakenE.
REQ-024 SHALL drive FlushE = LDRstall|BranchTakenE.
REQ-025 SHALL apply all rules when LDRstall and BranchTakenE are asserted in the same cycle: StallF=StallD=FlushE=FlushD=1.
REQ-026 SHALL increment stall_cnt on each rising edge with StallF=1, saturating at all-ones with no wrap.
REQ-027 SHALL increment flush_cnt on each rising edge with FlushE=1, saturating at all-ones with no wrap.
REQ-028 SHALL add zero latency on hazard outputs (combinational from inputs and shadow state); the counters SHALL lag by one cycle.

Reset
REQ-029 SHALL, while rst=0, asynchronously clear RA1E, RA2E, WA3E, WA3M, WA3W, stall_cnt, flush_cnt.
REQ-030 SHALL force ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE to 0 while rst=0.
REQ-031 SHALL, when reset is asserted mid-operation, discard any pending stall or forward and restart from the cleared state on the first edge after rst rises.

Structure
REQ-032 SHALL take the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and PC_REG=4'd15 from the shared CPU package.
REQ-033 SHALL instantiate the existing Register_rsten block for the shadow address registers; the saturating counter SHALL be a sub-module, sat_counter, instantiated twice.

Verification
REQ-034 SHALL verify: ADD R1 in Memory (WA3M=1, RegWriteM=1), RA1E=1 -> ForwardAE=10; with RegWriteW=1 and WA3W=1 also -> still 10.
REQ-035 SHALL verify: LDR R2 in Execute (MemtoRegE=1, RegWriteE=1, WA3E=2), RA2D=2 -> StallF=StallD=FlushE=1 for exactly one cycle, then ForwardBE=01 two cycles later.
REQ-036 SHALL verify: BranchTakenE=1 -> FlushD=FlushE=1 that cycle, and flush_cnt increments by 1 on the next edge.
REQ-037 SHALL verify: PCSrcD pulse flowing D->E->M->W -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles.
REQ-038 SHALL verify: WA3M=15 with RegWriteM=1 and RA1E=15 -> ForwardAE=00.
REQ-039 SHALL verify: hold StallF=1 for 2^CNT_W+5 cycles -> stall_cnt stops at all-ones; asserting rst=0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared CPU definitions used by the hazard unit: forwarding select codes,
// the PC register index and the Execute-stage shadow address bundle.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

    typedef logic [3:0] regAddr_t;

    typedef struct packed {
        regAddr_t ra1;
        regAddr_t ra2;
        regAddr_t wa3;
    } exAddr_t;

    // Memory wins over Writeback because it holds the younger result.
    function automatic logic [1:0] fwdSel(
        input regAddr_t ra,
        input regAddr_t waM,
        input logic     weM,
        input regAddr_t waW,
        input logic     weW
    );
        logic hitM;
        logic hitW;
        logic [1:0] sel;
        hitM = weM && (ra == waM) && (waM != PC_REG);
        hitW = weW && (ra == waW) && (waW != PC_REG);
        sel  = FWD_RF;
        priority case (1'b1)
            hitM:    sel = FWD_MEM;
            hitW:    sel = FWD_WB;
            default: sel = FWD_RF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_register_rsten.sv
// Register with async active-low reset, synchronous clear and load enable.
// Clear dominates enable so a flush always wins over a load.
module Register_rsten #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, PC-write and
// branch flushes, plus saturating stall/flush performance counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    exAddr_t                   exD;
    exAddr_t                   exQ;
    logic [$bits(exAddr_t)-1:0] exQBits;
    regAddr_t                  wa3M;
    regAddr_t                  wa3W;

    logic ldrStall;
    logic pcWrPending;
    logic stallFRaw;
    logic stallDRaw;
    logic flushDRaw;
    logic flushERaw;

    assign exD = '{ra1: RA1D, ra2: RA2D, wa3: WA3D};
    assign exQ = exQBits;

    Register_rsten #(
        .W($bits(exAddr_t))
    ) exRegs (
        .clock(clock),
        .rst  (rst),
        .en   (!stallDRaw),
        .clr  (flushERaw),
        .d    (exD),
        .q    (exQBits)
    );

    // Destination addresses keep moving even while the front end is stalled.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wa3M <= '0;
            wa3W <= '0;
        end else begin
            wa3M <= exQ.wa3;
            wa3W <= wa3M;
        end
    end

    assign ldrStall = MemtoRegE & RegWriteE &
                      ((RA1D == exQ.wa3) | (RA2D == exQ.wa3));

    assign pcWrPending = PCSrcD | PCSrcE | PCSrcM;

    assign stallFRaw = ldrStall | pcWrPending;
    assign stallDRaw = ldrStall;
    assign flushDRaw = pcWrPending | PCSrcW | BranchTakenE;
    assign flushERaw = ldrStall | BranchTakenE;

    // Outputs are held quiet for the whole time reset is asserted.
    assign StallF = rst & stallFRaw;
    assign StallD = rst & stallDRaw;
    assign FlushD = rst & flushDRaw;
    assign FlushE = rst & flushERaw;

    assign ForwardAE = rst ? fwdSel(exQ.ra1, wa3M, RegWriteM, wa3W, RegWriteW)
                           : FWD_RF;
    assign ForwardBE = rst ? fwdSel(exQ.ra2, wa3M, RegWriteM, wa3W, RegWriteW)
                           : FWD_RF;

    sat_counter #(
        .CNT_W(CNT_W)
    ) stallCounter (
        .clock(clock),
        .rst  (rst),
        .inc  (StallF),
        .count(stall_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) flushCounter (
        .clock(clock),
        .rst  (rst),
        .inc  (FlushE),
        .count(flush_cnt)
    );

endmodule
